// File: rtl/teclado_ps2_pkg.sv
// Shared definitions for the PS/2 keyboard front end.
//   - Set-2 scancode constants for the prefixes and for every key the game uses.
//   - State enums for the frame receiver and the scancode decoder.
//   - Debug struct that exposes both FSM states at the top level.
package teclado_ps2_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_F     = 8'h2B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATOS,
    RX_PARIDAD,
    RX_PARADA
  } rx_state_t;

  typedef enum logic [1:0] {
    D_NORMAL,
    D_EXT,
    D_BREAK,
    D_EXT_BREAK
  } dec_state_t;

  typedef struct packed {
    rx_state_t  rx;
    dec_state_t dec;
  } teclado_dbg_t;

endpackage

// File: rtl/teclado_ps2_receptor.sv
// PS/2 frame receiver.
//   clk, rst_n         system clock, asynchronous active-low reset
//   ps2_clk, ps2_data  raw asynchronous PS/2 lines
//   rx_byte            last byte received with good parity and stop bit
//   byte_ok            one-cycle pulse, rx_byte just updated
//   byte_err           one-cycle pulse, parity or stop-bit error (byte dropped)
//   rx_state           current frame FSM state (debug)
// Both lines pass a 2-FF synchronizer; ps2_clk is then debounced by requiring
// FILTER_LEN equal consecutive samples. A filtered falling edge samples data.
// A partial frame is abandoned after TIMEOUT_CYC cycles without an edge.
module receptor_ps2
  import teclado_ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_ok,
  output logic       byte_err,
  output rx_state_t  rx_state
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  logic                  clk_s1, clk_s2, data_s1, data_s2;
  logic [FILTER_LEN-1:0] clk_hist;
  logic                  filt, filt_d;
  logic                  strobe;
  logic                  timeout;
  logic [TW-1:0]         tcnt;
  logic [7:0]            shift;
  logic [2:0]            bit_cnt;
  logic                  par_bit;

  // Everything resets high: an idle PS/2 bus floats high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      clk_hist <= '1;
      filt     <= 1'b1;
      filt_d   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      data_s1  <= ps2_data;
      data_s2  <= data_s1;
      clk_hist <= {clk_hist[FILTER_LEN-2:0], clk_s2};
      // Level changes only once the whole history agrees; glitches shorter
      // than FILTER_LEN samples leave filt untouched.
      if (&clk_hist)
        filt <= 1'b1;
      else if (~|clk_hist)
        filt <= 1'b0;
      filt_d   <= filt;
    end
  end

  assign strobe  = filt_d & ~filt;
  assign timeout = (rx_state != RX_IDLE) && !strobe && (tcnt == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_IDLE;
      tcnt     <= '0;
      shift    <= 8'h00;
      bit_cnt  <= 3'd0;
      par_bit  <= 1'b0;
      rx_byte  <= 8'h00;
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
    end else begin
      byte_ok  <= 1'b0;
      byte_err <= 1'b0;
      if (strobe || timeout || rx_state == RX_IDLE)
        tcnt <= '0;
      else
        tcnt <= tcnt + 1'b1;

      if (timeout) begin
        rx_state <= RX_IDLE;
        bit_cnt  <= 3'd0;
      end else if (strobe) begin
        case (rx_state)
          RX_IDLE: begin
            // A high data bit on the first edge is a false start.
            if (!data_s2) begin
              rx_state <= RX_DATOS;
              bit_cnt  <= 3'd0;
            end
          end
          RX_DATOS: begin
            shift   <= {data_s2, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7)
              rx_state <= RX_PARIDAD;
          end
          RX_PARIDAD: begin
            par_bit  <= data_s2;
            rx_state <= RX_PARADA;
          end
          RX_PARADA: begin
            rx_state <= RX_IDLE;
            if ((^{shift, par_bit}) && data_s2) begin
              rx_byte <= shift;
              byte_ok <= 1'b1;
            end else begin
              byte_err <= 1'b1;
            end
          end
          default: rx_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/teclado_ps2.sv
// PS/2 keyboard front end for the buscaminas game.
//   clk, rst            system clock, asynchronous active-low reset
//   ps2_clk, ps2_data   raw PS/2 lines from the board pins
//   iniciar, seleccionarCasilla, marcarBandera,
//   esArriba, esAbajo, esIzquierda, esDerecha
//                       one-cycle command pulses, two cycles after the stop edge
//   scancode            last good byte; scancode_valid pulses when it updates
//   error_trama         one-cycle pulse on a parity or stop-bit error
//   dbg                 receiver and decoder FSM states
// Optional macro TECLADO_WASD_EN: W/S/A/D (non-extended) also drive the arrows.
module teclado_ps2
  import teclado_ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic         iniciar,
  output logic         seleccionarCasilla,
  output logic         marcarBandera,
  output logic         esArriba,
  output logic         esAbajo,
  output logic         esIzquierda,
  output logic         esDerecha,
  output logic [7:0]   scancode,
  output logic         scancode_valid,
  output logic         error_trama,
  output teclado_dbg_t dbg
);

  logic [7:0] rx_byte;
  logic       byte_ok;
  logic       byte_err;
  rx_state_t  rx_state;
  dec_state_t dec_state;
  logic       ext;

  receptor_ps2 #(
    .FILTER_LEN  (FILTER_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_receptor (
    .clk      (clk),
    .rst_n    (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte),
    .byte_ok  (byte_ok),
    .byte_err (byte_err),
    .rx_state (rx_state)
  );

  assign scancode       = rx_byte;
  assign scancode_valid = byte_ok;
  assign error_trama    = byte_err;
  assign ext            = (dec_state == D_EXT);
  assign dbg.rx         = rx_state;
  assign dbg.dec        = dec_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dec_state          <= D_NORMAL;
      iniciar            <= 1'b0;
      seleccionarCasilla <= 1'b0;
      marcarBandera      <= 1'b0;
      esArriba           <= 1'b0;
      esAbajo            <= 1'b0;
      esIzquierda        <= 1'b0;
      esDerecha          <= 1'b0;
    end else begin
      iniciar            <= 1'b0;
      seleccionarCasilla <= 1'b0;
      marcarBandera      <= 1'b0;
      esArriba           <= 1'b0;
      esAbajo            <= 1'b0;
      esIzquierda        <= 1'b0;
      esDerecha          <= 1'b0;
      if (byte_err) begin
        // A corrupted byte may have been a prefix; resynchronise.
        dec_state <= D_NORMAL;
      end else if (byte_ok) begin
        if (rx_byte == SC_EXT) begin
          dec_state <= D_EXT;
        end else if (rx_byte == SC_BREAK) begin
          dec_state <= (dec_state == D_EXT) ? D_EXT_BREAK : D_BREAK;
        end else begin
          dec_state <= D_NORMAL;
          // Release codes (after F0) never produce a command.
          if (dec_state == D_NORMAL || dec_state == D_EXT) begin
            case (rx_byte)
              SC_SPACE: if (!ext) iniciar            <= 1'b1;
              SC_ENTER: if (!ext) seleccionarCasilla <= 1'b1;
              SC_F:     if (!ext) marcarBandera      <= 1'b1;
              // Arrows with E0, or keypad 8/2/4/6 without it.
              SC_UP:    esArriba    <= 1'b1;
              SC_DOWN:  esAbajo     <= 1'b1;
              SC_LEFT:  esIzquierda <= 1'b1;
              SC_RIGHT: esDerecha   <= 1'b1;
`ifdef TECLADO_WASD_EN
              SC_W:     if (!ext) esArriba    <= 1'b1;
              SC_S:     if (!ext) esAbajo     <= 1'b1;
              SC_A:     if (!ext) esIzquierda <= 1'b1;
              SC_D:     if (!ext) esDerecha   <= 1'b1;
`endif
              default: ;
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_teclado_ps2.sv
// Self-checking bench for teclado_ps2: serial PS/2 frames in, scoreboard of
// expected scancode/error/command events out.
module tb_teclado_ps2;
  import teclado_ps2_pkg::*;

  localparam int FLEN = 4;
  localparam int TOUT = 1000;
  localparam int HALF = 20;  // PS/2 half period in clk cycles

  localparam logic [3:0] EV_SCV   = 4'h1;
  localparam logic [3:0] EV_ERR   = 4'h2;
  localparam logic [3:0] EV_INI   = 4'h3;
  localparam logic [3:0] EV_SEL   = 4'h4;
  localparam logic [3:0] EV_FLAG  = 4'h5;
  localparam logic [3:0] EV_UP    = 4'h6;
  localparam logic [3:0] EV_DOWN  = 4'h7;
  localparam logic [3:0] EV_LEFT  = 4'h8;
  localparam logic [3:0] EV_RIGHT = 4'h9;

  logic         clk;
  logic         rst;
  logic         ps2_clk;
  logic         ps2_data;
  logic         iniciar, seleccionarCasilla, marcarBandera;
  logic         esArriba, esAbajo, esIzquierda, esDerecha;
  logic [7:0]   scancode;
  logic         scancode_valid;
  logic         error_trama;
  teclado_dbg_t dbg;

  logic [11:0]  exp_q[$];
  int           n_cmp;
  int           n_fail;

  teclado_ps2 #(
    .FILTER_LEN  (FLEN),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .ps2_clk            (ps2_clk),
    .ps2_data           (ps2_data),
    .iniciar            (iniciar),
    .seleccionarCasilla (seleccionarCasilla),
    .marcarBandera      (marcarBandera),
    .esArriba           (esArriba),
    .esAbajo            (esAbajo),
    .esIzquierda        (esIzquierda),
    .esDerecha          (esDerecha),
    .scancode           (scancode),
    .scancode_valid     (scancode_valid),
    .error_trama        (error_trama),
    .dbg                (dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [11:0] ev(input logic [3:0] k, input logic [7:0] v);
    return {k, v};
  endfunction

  // Driver tasks
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par);
    logic par;
    par = ~(^b) ^ bad_par;
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic send_byte(input logic [7:0] b, input logic bad_par);
    send_bits(mk_frame(b, bad_par), 11);
  endtask

  // Scoreboard: pops one expected event per observed output pulse
  task automatic monitor_loop();
    logic [11:0] obs[$];
    logic [11:0] e;
    logic [6:0]  cmds;
    logic [6:0]  prev_cmds;
    logic        prev_valid;
    prev_cmds  = '0;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_cmds  = '0;
        prev_valid = 1'b0;
      end else begin
        cmds = {iniciar, seleccionarCasilla, marcarBandera,
                esArriba, esAbajo, esIzquierda, esDerecha};
        obs.delete();
        if (scancode_valid)     obs.push_back(ev(EV_SCV, scancode));
        if (error_trama)        obs.push_back(ev(EV_ERR, 8'h00));
        if (iniciar)            obs.push_back(ev(EV_INI, 8'h00));
        if (seleccionarCasilla) obs.push_back(ev(EV_SEL, 8'h00));
        if (marcarBandera)      obs.push_back(ev(EV_FLAG, 8'h00));
        if (esArriba)           obs.push_back(ev(EV_UP, 8'h00));
        if (esAbajo)            obs.push_back(ev(EV_DOWN, 8'h00));
        if (esIzquierda)        obs.push_back(ev(EV_LEFT, 8'h00));
        if (esDerecha)          obs.push_back(ev(EV_RIGHT, 8'h00));
        foreach (obs[k]) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_event: got %h, expected no event", obs[k]);
          end else begin
            e = exp_q.pop_front();
            if (obs[k] !== e) begin
              n_fail++;
              $display("FAIL sb_event: got %h, expected %h", obs[k], e);
            end
          end
        end
        if (cmds != 7'd0) begin
          n_cmp++;
          if (!prev_valid || prev_cmds != 7'd0 || $countones(cmds) != 1) begin
            n_fail++;
            $display("FAIL cmd_timing: cmds=%b prev_valid=%b prev_cmds=%b, required one-hot 1 clk right after scancode_valid",
                     cmds, prev_valid, prev_cmds);
          end
        end
        prev_valid = scancode_valid;
        prev_cmds  = cmds;
      end
    end
  endtask

  // Scenarios
  task automatic test_reset();
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if (scancode !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_scancode: got %h, expected 00", scancode);
    end
    n_cmp++;
    if ({iniciar, seleccionarCasilla, marcarBandera, esArriba, esAbajo, esIzquierda,
         esDerecha, scancode_valid, error_trama} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_pulses: got nonzero pulse outputs, expected all 0");
    end
    n_cmp++;
    if (dbg !== '{rx: RX_IDLE, dec: D_NORMAL}) begin
      n_fail++;
      $display("FAIL reset_state: got %h, expected idle/normal", dbg);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_space();
    exp_q.push_back(ev(EV_SCV, SC_SPACE));
    exp_q.push_back(ev(EV_INI, 8'h00));
    send_byte(SC_SPACE, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL space_drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (scancode !== SC_SPACE) begin
      n_fail++;
      $display("FAIL space_scancode: got %h, expected 29", scancode);
    end
  endtask

  task automatic test_arrow_ext();
    logic [7:0] seq [6] = '{SC_EXT, SC_UP, SC_EXT, SC_BREAK, SC_UP, SC_ENTER};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(ev(EV_SCV, seq[i]));
      if (i == 1) exp_q.push_back(ev(EV_UP, 8'h00));
      if (i == 5) exp_q.push_back(ev(EV_SEL, 8'h00));
      send_byte(seq[i], 1'b0);
      if (i == 4) begin
        n_cmp++;
        if (dbg.dec !== D_NORMAL) begin
          n_fail++;
          $display("FAIL release_dec: got %0d, expected D_NORMAL", dbg.dec);
        end
      end
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL arrow_drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_parity_error();
    exp_q.push_back(ev(EV_ERR, 8'h00));
    send_byte(SC_F, 1'b1);
    n_cmp++;
    if (scancode !== SC_ENTER) begin
      n_fail++;
      $display("FAIL err_scancode: got %h, expected 5a (unchanged)", scancode);
    end
    exp_q.push_back(ev(EV_SCV, SC_F));
    exp_q.push_back(ev(EV_FLAG, 8'h00));
    send_byte(SC_F, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL parity_drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_timeout();
    exp_q.push_back(ev(EV_SCV, SC_EXT));
    send_byte(SC_EXT, 1'b0);
    send_bits(mk_frame(SC_EXT, 1'b0), 5);
    n_cmp++;
    if (dbg.rx !== RX_DATOS) begin
      n_fail++;
      $display("FAIL partial_state: got %0d, expected RX_DATOS", dbg.rx);
    end
    repeat (TOUT + 200) @(negedge clk);
    n_cmp++;
    if (dbg.rx !== RX_IDLE) begin
      n_fail++;
      $display("FAIL timeout_state: got %0d, expected RX_IDLE", dbg.rx);
    end
    exp_q.push_back(ev(EV_SCV, SC_EXT));
    exp_q.push_back(ev(EV_SCV, SC_RIGHT));
    exp_q.push_back(ev(EV_RIGHT, 8'h00));
    send_byte(SC_EXT, 1'b0);
    send_byte(SC_RIGHT, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL timeout_drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_glitch();
    ps2_data = 1'b0;
    @(negedge clk);
    ps2_clk = 1'b0;
    repeat (2) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    n_cmp++;
    if (dbg.rx !== RX_IDLE) begin
      n_fail++;
      $display("FAIL glitch_state: got %0d, expected RX_IDLE", dbg.rx);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [7] = '{SC_ENTER, SC_ENTER, SC_ENTER, SC_DOWN, SC_LEFT, SC_BREAK, SC_F};
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back(ev(EV_SCV, seq[i]));
      if (i < 3)  exp_q.push_back(ev(EV_SEL, 8'h00));
      if (i == 3) exp_q.push_back(ev(EV_DOWN, 8'h00));
      if (i == 4) exp_q.push_back(ev(EV_LEFT, 8'h00));
      send_byte(seq[i], 1'b0);
    end
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL b2b_drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_wasd();
    exp_q.push_back(ev(EV_SCV, SC_W));
`ifdef TECLADO_WASD_EN
    exp_q.push_back(ev(EV_UP, 8'h00));
`endif
    send_byte(SC_W, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL wasd_drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    if (scancode !== SC_W) begin
      n_fail++;
      $display("FAIL wasd_scancode: got %h, expected 1d", scancode);
    end
  endtask

  task automatic test_rst_mid_frame();
    send_bits(mk_frame(SC_ENTER, 1'b0), 4);
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (scancode !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_scancode: got %h, expected 00", scancode);
    end
    n_cmp++;
    if (dbg !== '{rx: RX_IDLE, dec: D_NORMAL}) begin
      n_fail++;
      $display("FAIL rst_mid_state: got %h, expected idle/normal", dbg);
    end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    exp_q.push_back(ev(EV_SCV, SC_SPACE));
    exp_q.push_back(ev(EV_INI, 8'h00));
    send_byte(SC_SPACE, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL rst_mid_drain: %0d events still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Sequencer and final report
  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst      = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    fork
      monitor_loop();
    join_none
    test_reset();
    test_space();
    test_arrow_ext();
    test_parity_error();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_wasd();
    test_rst_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
